// File: rtl/key_debounce_if.sv
// Key pin and debounced key outputs, grouped for a single user key.
interface key_debounce_if;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;

  modport master (
    output key_in,
    input  key_level, key_press, key_release, key_long
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Synchronises a raw key pin and debounces it into a clean level plus
// one-cycle press / release / long-press pulses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input logic           sys_clk,
  input logic           sys_rst,
  key_debounce_if.slave key
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic              PIN_IDLE  = KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic              key_act;
  logic [DB_W-1:0]   db_q, db_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_done_q, long_done_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Sync flops idle at the released pin level so reset never looks like a press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) sync_q <= {2{PIN_IDLE}};
    else         sync_q <= {sync_q[0], key.key_in};
  end

  assign key_act = sync_q[1] ^ KEY_ACTIVE_LOW;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      db_q        <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_q        <= db_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    db_d        = db_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_act) begin
          state_d = PRESS_DB;
          db_d    = '0;
        end
      end
      PRESS_DB: begin
        if (!key_act) begin
          state_d = IDLE;
        end else if (db_q == DB_LAST) begin
          state_d     = PRESSED;
          press_d     = 1'b1;
          level_d     = 1'b1;
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      PRESSED: begin
        if (hold_q < HOLD_MAX) hold_d = hold_q + 1'b1;
        // Evaluated before the exit check so a long pulse can share the drop cycle.
        if (hold_q == HOLD_LAST && !long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
        if (!key_act) begin
          state_d = REL_DB;
          db_d    = '0;
        end
      end
      REL_DB: begin
        // A release bounce resumes the hold timer where it paused.
        if (key_act) begin
          state_d = PRESSED;
        end else if (db_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key.key_level   = level_q;
  assign key.key_press   = press_q;
  assign key.key_release = release_q;
  assign key.key_long    = long_q;
endmodule
